gf2_mul_scheduler: RTL

Multi-cycle controller for 409x409 binary-polynomial (carry-less, GF(2)[x]) multiplication. It splits both operands into four limbs and time-multiplexes one bit-serial 103x103 carry-less MAC across all 16 limb products. Each product is XOR-accumulated into an 818-bit result at the correct limb offset. It presents valid/ready handshakes on the operand side and on the result side, so it can sit in place of the fully parallel Toom-Cook array where area matters more than latency.

---
 rtl/gf2_mul_scheduler_pkg.sv | 37 +++
 rtl/gf2_mul_scheduler_if.sv | 24 ++
 rtl/gf2_mul_scheduler_mac.sv | 36 +++
 rtl/gf2_mul_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/gf2_mul_scheduler_pkg.sv
// Shared constants, limb map and FSM encoding for the limb-serial GF(2)[x] multiplier.
package gf2_mul_pkg;

  localparam int unsigned N   = 409;
  localparam int unsigned LW  = 103;
  localparam int unsigned NL  = 4;
  localparam int unsigned PW  = 2 * LW - 1;
  localparam int unsigned CW  = 2 * N;
  localparam int unsigned BIW = 7;
  localparam int unsigned OFW = 10;

  localparam int unsigned LIMB_OFF [NL] = '{0, 103, 205, 307};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  // Upper limbs are one bit short of LW and are zero-extended.
  function automatic logic [LW-1:0] limb(input logic [N-1:0] v, input logic [1:0] idx);
    limb = '0;
    case (idx)
      2'd0: limb = v[102:0];
      2'd1: limb = {1'b0, v[204:103]};
      2'd2: limb = {1'b0, v[306:205]};
      2'd3: limb = {1'b0, v[408:307]};
      default: limb = '0;
    endcase
  endfunction

  function automatic logic [OFW-1:0] pair_off(input logic [1:0] i, input logic [1:0] j);
    pair_off = OFW'(LIMB_OFF[i] + LIMB_OFF[j]);
  endfunction

endpackage

// File: rtl/gf2_mul_scheduler_if.sv
// Operand/result handshake bundle for gf2_mul_scheduler.
interface gf2_mul_scheduler_if;
  import gf2_mul_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c;
  logic          busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, busy
  );

endinterface

// File: rtl/gf2_mul_scheduler_mac.sv
// Bit-serial LW x LW carry-less MAC: one shift-XOR step per enabled cycle.
module gf2_serial_mac
  import gf2_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           abit,
  input  logic [LW-1:0]  b,
  input  logic [BIW-1:0] bit_idx,
  output logic [PW-1:0]  prod
);

  logic [PW-1:0] prod_q, prod_d;

  always_comb begin
    prod_d = prod_q;
    if (clr) begin
      prod_d = '0;
    end else if (en && abit) begin
      prod_d = prod_q ^ (PW'(b) << bit_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/gf2_mul_scheduler.sv
// 409x409 carry-less multiplier: 16 limb products through one serial MAC, XOR-accumulated.
module gf2_mul_scheduler
  import gf2_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  gf2_mul_scheduler_if.slave bus
);

  localparam logic [BIW-1:0] LAST_BIT  = BIW'(LW - 1);
  localparam logic [3:0]     LAST_PAIR = 4'd15;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  acc_q, acc_d;
  logic [3:0]     p_q, p_d;
  logic [BIW-1:0] bit_q, bit_d;

  logic           mac_clr, mac_en;
  logic [LW-1:0]  a_limb, b_limb;
  logic [PW-1:0]  prod;
  logic [OFW-1:0] off;
  logic [CW-1:0]  prod_sh;

  // Pair index p: upper two bits pick the A limb, lower two the B limb.
  assign a_limb  = limb(a_q, p_q[3:2]);
  assign b_limb  = limb(b_q, p_q[1:0]);
  assign off     = pair_off(p_q[3:2], p_q[1:0]);
  assign prod_sh = CW'(prod) << off;

  gf2_serial_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .abit    (a_limb[bit_q]),
    .b       (b_limb),
    .bit_idx (bit_q),
    .prod    (prod)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    bit_d   = bit_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          p_d     = '0;
          bit_d   = '0;
          mac_clr = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mac_en = 1'b1;
        if (bit_q == LAST_BIT) begin
          state_d = ACC;
        end else begin
          bit_d = bit_q + BIW'(1);
        end
      end
      ACC: begin
        acc_d   = acc_q ^ prod_sh;
        mac_clr = 1'b1;
        if (p_q == LAST_PAIR) begin
          state_d = DONE;
        end else begin
          p_d     = p_q + 4'd1;
          bit_d   = '0;
          state_d = MUL;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.c         = acc_q;

endmodule
